// File: rtl/loc_walker_pkg.sv
// rtl/loc_walker_pkg.sv - shared direction codes, walker states and direction helpers
package loc_walker_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_YDEC = 2'b00;
  localparam dir_t DIR_XINC = 2'b01;
  localparam dir_t DIR_XDEC = 2'b10;
  localparam dir_t DIR_YINC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The encoding is chosen so that the opposite move is the bitwise complement.
  function automatic dir_t inv_dir(input dir_t d);
    return ~d;
  endfunction

endpackage

// File: rtl/loc_walker_if.sv
// rtl/loc_walker_if.sv - request/status bundle between a walker controller and loc_walker
interface loc_walker_if #(
  parameter int COORD_W     = 4,
  parameter int STACK_DEPTH = 16
);
  localparam int LOC_W   = 2 * COORD_W;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               start;
  logic [LOC_W-1:0]   start_loc;
  logic [LOC_W-1:0]   goal_loc;
  logic               step_valid;
  logic [1:0]         step_dir;
  logic               undo_valid;
  logic               step_ready;
  logic [LOC_W-1:0]   cur_loc;
  logic               at_edge;
  logic               blocked;
  logic               goal_reached;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output start, start_loc, goal_loc, step_valid, step_dir, undo_valid,
    input  step_ready, cur_loc, at_edge, blocked, goal_reached, depth
  );

  modport slave (
    input  start, start_loc, goal_loc, step_valid, step_dir, undo_valid,
    output step_ready, cur_loc, at_edge, blocked, goal_reached, depth
  );

endinterface

// File: rtl/dir_stack.sv
// rtl/dir_stack.sv - LIFO of accepted move directions used for undo
module dir_stack
  import loc_walker_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  dir_t             din,
  output dir_t             top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  dir_t             mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - ONE_C);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + ONE_C;
    end else if (do_pop) begin
      count <= count - ONE_C;
    end
  end

  // Entries above count are stale by construction, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/loc_walker.sv
// rtl/loc_walker.sv - grid walker with edge checking, undo history and goal detection
module loc_walker
  import loc_walker_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int STACK_DEPTH = 16,
  parameter int WRAP        = 0
) (
  input  logic         clk,
  input  logic         rst,
  loc_walker_if.slave  bus
);

  localparam int LOC_W   = 2 * COORD_W;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [COORD_W-1:0] MAX_C = '1;
  localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);

  state_t             state;
  state_t             state_nx;
  logic [LOC_W-1:0]   cur_loc;
  logic [LOC_W-1:0]   loc_nx;
  logic               blocked;
  logic               blocked_nx;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               at_edge;
  logic               step_ready;
  logic               do_step;
  logic               do_undo;
  logic               step_ok;
  logic               undo_ok;
  dir_t               top_dir;
  logic               stk_full;
  logic               stk_empty;
  logic [DEPTH_W-1:0] stk_count;

  // Each axis wraps within COORD_W bits; legality is decided by at_edge, not carry.
  function automatic logic [LOC_W-1:0] move(input logic [LOC_W-1:0] loc, input dir_t d);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    x = loc[LOC_W-1:COORD_W];
    y = loc[COORD_W-1:0];
    case (d)
      DIR_YDEC: y = y - ONE_C;
      DIR_XINC: x = x + ONE_C;
      DIR_XDEC: x = x - ONE_C;
      default:  y = y + ONE_C;
    endcase
    return {x, y};
  endfunction

  assign cur_x = cur_loc[LOC_W-1:COORD_W];
  assign cur_y = cur_loc[COORD_W-1:0];

  always_comb begin
    at_edge = 1'b0;
    case (bus.step_dir)
      DIR_YDEC: at_edge = (cur_y == '0);
      DIR_XINC: at_edge = (cur_x == MAX_C);
      DIR_XDEC: at_edge = (cur_x == '0);
      default:  at_edge = (cur_y == MAX_C);
    endcase
  end

  assign step_ready = (state == ST_RUN) && !bus.start;
  assign do_undo    = bus.undo_valid && step_ready;
  assign undo_ok    = do_undo && !stk_empty;
  assign do_step    = bus.step_valid && step_ready && !bus.undo_valid;
  assign step_ok    = do_step && !stk_full && ((WRAP != 0) || !at_edge);

  always_comb begin
    state_nx   = state;
    loc_nx     = cur_loc;
    blocked_nx = (do_undo && stk_empty) || (do_step && !step_ok);
    if (bus.start) begin
      state_nx = ST_RUN;
      loc_nx   = bus.start_loc;
    end else begin
      if (undo_ok) begin
        loc_nx = move(cur_loc, inv_dir(top_dir));
      end else if (step_ok) begin
        loc_nx = move(cur_loc, bus.step_dir);
      end
      // Goal compares the registered location, so arrival is seen one edge later.
      if ((state == ST_RUN) && (cur_loc == bus.goal_loc)) begin
        state_nx = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur_loc <= '0;
      blocked <= 1'b0;
    end else begin
      state   <= state_nx;
      cur_loc <= loc_nx;
      blocked <= blocked_nx;
    end
  end

  dir_stack #(
    .DEPTH (STACK_DEPTH),
    .CNT_W (DEPTH_W)
  ) u_dir_stack (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.start),
    .push  (step_ok),
    .pop   (undo_ok),
    .din   (bus.step_dir),
    .top   (top_dir),
    .full  (stk_full),
    .empty (stk_empty),
    .count (stk_count)
  );

  assign bus.step_ready   = step_ready;
  assign bus.cur_loc      = cur_loc;
  assign bus.at_edge      = at_edge;
  assign bus.blocked      = blocked;
  assign bus.goal_reached = (state == ST_DONE);
  assign bus.depth        = stk_count;

endmodule

// File: tb/tb_loc_walker.sv
// tb/tb_loc_walker.sv - three walker configurations against a grid model, vectors and random traffic
module tb_loc_walker;

  localparam int M = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_loc;
  logic [7:0] goal_loc;
  logic       step_valid;
  logic [1:0] step_dir;
  logic       undo_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  loc_walker_if #(.COORD_W(4), .STACK_DEPTH(16)) bus0 ();
  loc_walker_if #(.COORD_W(4), .STACK_DEPTH(16)) bus1 ();
  loc_walker_if #(.COORD_W(4), .STACK_DEPTH(4))  bus2 ();

  assign {bus0.start, bus0.start_loc, bus0.goal_loc, bus0.step_valid, bus0.step_dir, bus0.undo_valid} =
         {start, start_loc, goal_loc, step_valid, step_dir, undo_valid};
  assign {bus1.start, bus1.start_loc, bus1.goal_loc, bus1.step_valid, bus1.step_dir, bus1.undo_valid} =
         {start, start_loc, goal_loc, step_valid, step_dir, undo_valid};
  assign {bus2.start, bus2.start_loc, bus2.goal_loc, bus2.step_valid, bus2.step_dir, bus2.undo_valid} =
         {start, start_loc, goal_loc, step_valid, step_dir, undo_valid};

  loc_walker #(.COORD_W(4), .STACK_DEPTH(16), .WRAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  loc_walker #(.COORD_W(4), .STACK_DEPTH(16), .WRAP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  loc_walker #(.COORD_W(4), .STACK_DEPTH(4),  .WRAP(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [7:0] o_loc [3];
  logic [7:0] o_dep [3];
  logic       o_blk [3];
  logic       o_goal[3];
  logic       o_rdy [3];
  logic       o_edge[3];

  assign o_loc[0] = bus0.cur_loc;  assign o_dep[0] = 8'(bus0.depth);
  assign o_loc[1] = bus1.cur_loc;  assign o_dep[1] = 8'(bus1.depth);
  assign o_loc[2] = bus2.cur_loc;  assign o_dep[2] = 8'(bus2.depth);
  assign o_blk[0] = bus0.blocked;  assign o_goal[0] = bus0.goal_reached;
  assign o_blk[1] = bus1.blocked;  assign o_goal[1] = bus1.goal_reached;
  assign o_blk[2] = bus2.blocked;  assign o_goal[2] = bus2.goal_reached;
  assign o_rdy[0] = bus0.step_ready; assign o_edge[0] = bus0.at_edge;
  assign o_rdy[1] = bus1.step_ready; assign o_edge[1] = bus1.at_edge;
  assign o_rdy[2] = bus2.step_ready; assign o_edge[2] = bus2.at_edge;

  // Grid model: positions as plain integers, history as an array of moves.
  int cfg_depth[3] = '{16, 16, 4};
  int cfg_wrap [3] = '{0, 1, 0};
  int mx[3], my[3], md[3], mst[3];  // mst: 0 idle, 1 run, 2 done
  bit mblk[3];
  logic [1:0] stk[3][16];

  function automatic void delta(input logic [1:0] d, output int dx, output int dy);
    dx = 0; dy = 0;
    case (d)
      2'b00: dy = -1;
      2'b01: dx = 1;
      2'b10: dx = -1;
      default: dy = 1;
    endcase
  endfunction

  function automatic bit m_edge(input int c);
    int dx, dy, nx, ny;
    delta(step_dir, dx, dy);
    nx = mx[c] + dx;
    ny = my[c] + dy;
    return (nx < 0) || (nx >= M) || (ny < 0) || (ny >= M);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      mx[c] = 0; my[c] = 0; md[c] = 0; mst[c] = 0; mblk[c] = 0;
    end
  endfunction

  function automatic void model_next(input int c);
    int dx, dy, nx, ny;
    bit rdy, hit, out;
    rdy = (mst[c] == 1) && !start;
    hit = (mst[c] == 1) && (mx[c] == int'(goal_loc[7:4])) && (my[c] == int'(goal_loc[3:0]));
    out = m_edge(c);
    mblk[c] = 0;
    if (start) begin
      mx[c] = int'(start_loc[7:4]); my[c] = int'(start_loc[3:0]);
      md[c] = 0; mst[c] = 1;
      return;
    end
    if (rdy) begin
      if (undo_valid) begin
        if (md[c] == 0) mblk[c] = 1;
        else begin
          md[c]--;
          delta(stk[c][md[c]], dx, dy);
          mx[c] = (mx[c] - dx + M) % M;
          my[c] = (my[c] - dy + M) % M;
        end
      end else if (step_valid) begin
        delta(step_dir, dx, dy);
        nx = mx[c] + dx;
        ny = my[c] + dy;
        if (md[c] == cfg_depth[c] || (out && cfg_wrap[c] == 0)) mblk[c] = 1;
        else begin
          stk[c][md[c]] = step_dir;
          md[c]++;
          mx[c] = (nx + M) % M;
          my[c] = (ny + M) % M;
        end
      end
    end
    if (hit) mst[c] = 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("c%0d cur_loc", c), 32'(o_loc[c]), 32'(mx[c] * 16 + my[c]));
      chk($sformatf("c%0d depth", c), 32'(o_dep[c]), 32'(md[c]));
      chk($sformatf("c%0d blocked", c), 32'(o_blk[c]), 32'(mblk[c]));
      chk($sformatf("c%0d goal_reached", c), 32'(o_goal[c]), 32'(mst[c] == 2));
      chk($sformatf("c%0d step_ready", c), 32'(o_rdy[c]), 32'(mst[c] == 1 && !start && !rst));
      chk($sformatf("c%0d at_edge", c), 32'(o_edge[c]), 32'(m_edge(c)));
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else for (int c = 0; c < 3; c++) model_next(c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input bit st, input logic [7:0] sl, input logic [7:0] gl,
                        input bit sv, input logic [1:0] d, input bit uv);
    start = st; start_loc = sl; goal_loc = gl;
    step_valid = sv; step_dir = d; undo_valid = uv;
  endtask

  typedef struct {
    bit         st;
    logic [7:0] sl;
    logic [7:0] gl;
    bit         sv;
    logic [1:0] dir;
    bit         uv;
    logic [7:0] e_loc;
    int         e_dep;
    bit         e_blk;
    bit         e_edge;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1, 8'h00, 8'h22, 0, 2'b00, 0, 8'h00, 0, 0, 1};
    vt[1]  = '{0, 8'h00, 8'h22, 1, 2'b00, 0, 8'h00, 0, 1, 1};
    vt[2]  = '{0, 8'h00, 8'h22, 0, 2'b00, 0, 8'h00, 0, 0, 1};
    vt[3]  = '{1, 8'h11, 8'hFF, 0, 2'b00, 0, 8'h11, 0, 0, 0};
    vt[4]  = '{0, 8'h11, 8'hFF, 1, 2'b01, 0, 8'h21, 1, 0, 0};
    vt[5]  = '{0, 8'h11, 8'hFF, 1, 2'b01, 0, 8'h31, 2, 0, 0};
    vt[6]  = '{0, 8'h11, 8'hFF, 1, 2'b11, 0, 8'h32, 3, 0, 0};
    vt[7]  = '{0, 8'h11, 8'hFF, 0, 2'b11, 1, 8'h31, 2, 0, 0};
    vt[8]  = '{0, 8'h11, 8'hFF, 0, 2'b11, 1, 8'h21, 1, 0, 0};
    vt[9]  = '{0, 8'h11, 8'hFF, 0, 2'b11, 1, 8'h11, 0, 0, 0};
    vt[10] = '{0, 8'h11, 8'hFF, 0, 2'b11, 1, 8'h11, 0, 1, 0};
    vt[11] = '{0, 8'h11, 8'hFF, 0, 2'b00, 0, 8'h11, 0, 0, 0};

    rst = 1'b1;
    set_in(0, 8'h00, 8'h00, 0, 2'b00, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Requests in IDLE are ignored until start.
    set_in(0, 8'h00, 8'h00, 1, 2'b01, 0);
    tick();
    chk("idle step ignored", 32'(o_loc[0]), 32'h00);

    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].st, vt[i].sl, vt[i].gl, vt[i].sv, vt[i].dir, vt[i].uv);
      tick();
      chk($sformatf("vec%0d cur_loc", i), 32'(o_loc[0]), 32'(vt[i].e_loc));
      chk($sformatf("vec%0d depth", i), 32'(o_dep[0]), 32'(vt[i].e_dep));
      chk($sformatf("vec%0d blocked", i), 32'(o_blk[0]), 32'(vt[i].e_blk));
      chk($sformatf("vec%0d at_edge", i), 32'(o_edge[0]), 32'(vt[i].e_edge));
    end

    // Wrap across both axes.
    set_in(1, 8'h0F, 8'hFF, 0, 2'b00, 0); tick();
    set_in(0, 8'h0F, 8'hFF, 1, 2'b11, 0); tick();
    chk("wrap y cur_loc", 32'(o_loc[1]), 32'h00);
    chk("wrap y blocked", 32'(o_blk[1]), 32'h0);
    chk("nowrap y blocked", 32'(o_blk[0]), 32'h1);
    set_in(0, 8'h0F, 8'hFF, 1, 2'b10, 0); tick();
    chk("wrap x cur_loc", 32'(o_loc[1]), 32'hF0);
    chk("wrap x blocked", 32'(o_blk[1]), 32'h0);

    // Full history on the 4-deep instance, then undo beating a step.
    set_in(1, 8'h55, 8'hFF, 0, 2'b00, 0); tick();
    set_in(0, 8'h55, 8'hFF, 1, 2'b01, 0); tick();
    set_in(0, 8'h55, 8'hFF, 1, 2'b11, 0); tick();
    set_in(0, 8'h55, 8'hFF, 1, 2'b10, 0); tick();
    set_in(0, 8'h55, 8'hFF, 1, 2'b00, 0); tick();
    chk("full depth", 32'(o_dep[2]), 32'd4);
    set_in(0, 8'h55, 8'hFF, 1, 2'b01, 0); tick();
    chk("full blocked", 32'(o_blk[2]), 32'h1);
    chk("full depth kept", 32'(o_dep[2]), 32'd4);
    chk("full loc kept", 32'(o_loc[2]), 32'h55);
    set_in(0, 8'h55, 8'hFF, 1, 2'b01, 1); tick();
    chk("undo wins loc", 32'(o_loc[2]), 32'h56);
    chk("undo wins depth", 32'(o_dep[2]), 32'd3);
    chk("undo wins no blocked", 32'(o_blk[2]), 32'h0);

    // Goal reached one edge after arrival; DONE ignores steps.
    set_in(1, 8'h12, 8'h13, 0, 2'b00, 0); tick();
    set_in(0, 8'h12, 8'h13, 1, 2'b11, 0); tick();
    chk("arrive loc", 32'(o_loc[0]), 32'h13);
    chk("arrive goal not yet", 32'(o_goal[0]), 32'h0);
    set_in(0, 8'h12, 8'h13, 0, 2'b11, 0); tick();
    chk("done goal", 32'(o_goal[0]), 32'h1);
    chk("done not ready", 32'(o_rdy[0]), 32'h0);
    set_in(0, 8'h12, 8'h13, 1, 2'b01, 0); tick();
    chk("done step ignored", 32'(o_loc[0]), 32'h13);
    chk("done no blocked", 32'(o_blk[0]), 32'h0);
    set_in(1, 8'h12, 8'h13, 0, 2'b00, 0); tick();
    chk("restart goal clear", 32'(o_goal[0]), 32'h0);
    chk("restart loc", 32'(o_loc[0]), 32'h12);
    set_in(0, 8'h12, 8'h13, 0, 2'b00, 0);
    #1;
    chk("restart ready", 32'(o_rdy[0]), 32'h1);
    tick();

    // Randomised traffic.
    set_in(1, 8'h77, 8'h79, 0, 2'b00, 0); tick();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] sl;
      sl = 8'($urandom);
      set_in(($urandom % 25) == 0, sl,
             (($urandom % 3) == 0) ? (sl ^ 8'h01) : 8'($urandom),
             ($urandom % 4) != 0, 2'($urandom), ($urandom % 4) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a step stream.
    set_in(1, 8'h33, 8'hFF, 0, 2'b00, 0); tick();
    set_in(0, 8'h33, 8'hFF, 1, 2'b01, 0); tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async rst loc", 32'(o_loc[0]), 32'h00);
    chk("async rst depth", 32'(o_dep[0]), 32'h0);
    chk("async rst ready", 32'(o_rdy[0]), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post rst idle", 32'(o_loc[0]), 32'h00);
    set_in(1, 8'h44, 8'hFF, 0, 2'b00, 0); tick();
    set_in(0, 8'h44, 8'hFF, 1, 2'b10, 0); tick();
    chk("post rst restart", 32'(o_loc[0]), 32'h34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loc_walker.md
LOC_WALKER -- requirements
Module: loc_walker

Interface
REQ-001 Parameter COORD_W, default 4, coordinate width per axis; location width is 2*COORD_W.
REQ-002 Parameter STACK_DEPTH, default 16, maximum number of undoable moves held.
REQ-003 Parameter WRAP, default 0, 0 = edge moves rejected, 1 = edge moves wrap modulo 2**COORD_W.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  load start_loc, clear history, enter RUN.
REQ-007 start_loc  input  2*COORD_W  initial location {x, y}, x in upper half.
REQ-008 goal_loc  input  2*COORD_W  target location {x, y}.
REQ-009 step_valid  input  1  move request.
REQ-010 step_dir  input  2  move direction.
REQ-011 undo_valid  input  1  request to reverse the most recent accepted move.
REQ-012 step_ready  output  1  block accepts step/undo this cycle.
REQ-013 cur_loc  output  2*COORD_W  registered current location.
REQ-014 at_edge  output  1  combinational: step_dir from cur_loc would leave the grid.
REQ-015 blocked  output  1  one-cycle pulse: last request rejected.
REQ-016 goal_reached  output  1  high while in DONE.
REQ-017 depth  output  clog2(STACK_DEPTH+1)  number of moves on history stack.

Function
REQ-018 Direction encoding: 00 y-1, 01 x+1, 10 x-1, 11 y+1; inverse direction = bitwise NOT.
REQ-019 States: IDLE, RUN, DONE; reset enters IDLE.
REQ-020 start in any state: cur_loc <= start_loc, depth <= 0, state <= RUN on the next edge; start overrides step/undo in the same cycle.
REQ-021 step_ready = 1 only in RUN and when start is low.
REQ-022 Accepted step (step_valid & step_ready & !undo_valid): cur_loc updates at the next edge, direction pushed, depth+1; back-to-back steps are accepted every cycle.
REQ-023 Step rejected, cur_loc and depth unchanged, blocked=1 next cycle, when depth==STACK_DEPTH, or when at_edge=1 and WRAP=0.
REQ-024 With WRAP=1, edge step wraps: 0 - 1 -> 2**COORD_W-1, max + 1 -> 0; not blocked.
REQ-025 at_edge = 1 for: x==max with 01, x==0 with 10, y==max with 11, y==0 with 00; it is independent of WRAP and state.
REQ-026 Accepted undo (undo_valid & step_ready): pop the top direction, move by its inverse (always legal), depth-1; undo wins over a simultaneous step, and the step is dropped without a blocked pulse.
REQ-027 Undo with depth==0: blocked=1 next cycle, no change.
REQ-028 Goal check: in RUN, when the registered cur_loc==goal_loc, enter DONE on the next edge; this includes start_loc==goal_loc.
REQ-029 DONE: step_ready=0, step/undo ignored without blocked; only start or rst leave DONE.
REQ-030 IDLE: step_ready=0, requests ignored, blocked=0.
REQ-031 Only the non-moving axis retains its value; no carry from y into x.

Reset
REQ-032 rst asserted: cur_loc=0, depth=0, blocked=0, goal_reached=0, state IDLE, stack contents don't-care, applied immediately regardless of clk.
REQ-033 Reset mid-move discards any in-flight request; the first accepted move after release requires start.

Structure
REQ-034 The shared package shall hold the direction constants (DIR_YDEC, DIR_XINC, DIR_XDEC, DIR_YINC), the state enum, and an inverse-direction function.
REQ-035 A single sub-module, dir_stack, shall implement the STACK_DEPTH x 2 LIFO with push, pop, full, empty, count, and asynchronous reset.
REQ-036 The coordinate arithmetic shall be COORD_W-bit only; out-of-range detection uses at_edge, not carry-out.

Verification
REQ-037 rst; start with start_loc=8'h00, goal 8'h22, dir 00 -> at_edge=1, blocked pulse, cur_loc stays 8'h00 (WRAP=0).
REQ-038 start 8'h11, goal 8'hFF, steps 01,01,11 -> cur_loc 8'h21, 8'h31, 8'h32; depth 3; then undo x3 -> 8'h31, 8'h21, 8'h11, depth 0; fourth undo -> blocked.
REQ-039 WRAP=1, start 8'h0F, dir 11 -> cur_loc 8'h00, no blocked; dir 10 -> 8'hF0.
REQ-040 STACK_DEPTH=4, four accepted steps away from the edges, fifth step -> blocked, depth stays 4; simultaneous step+undo -> undo executes, depth 3.
REQ-041 start 8'h12, goal 8'h13, step 11 -> cur_loc 8'h13, goal_reached=1 after one further edge, step_ready=0, further steps ignored; start reenters RUN.
REQ-042 Assert rst asynchronously between clock edges during a step stream -> outputs zero immediately, IDLE, step_ready=0.
